uart_tx_serializer: RTL

//   UART transmit serializer. Sits directly downstream of the baud-rate divider.
//   It consumes the divider's square-wave baud clock (period = one bit time) as a

---
 rtl/uart_tx_serializer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: consumes a square-wave baud input, frames bytes as
// start/data(LSB first)/optional parity/stop, with a one-entry holding register.
module uart_tx_serializer #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 baud_i,
   input  logic [DATA_BITS-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic                 tx_o,
   output logic                 busy_o
);

   localparam int CW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   state_t               state_reg, state_next;
   logic                 baud_q_reg;
   logic [DATA_BITS-1:0] hold_reg, hold_next;
   logic                 hold_full_reg, hold_full_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 par_reg, par_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic                 tx_reg, tx_next;
   logic                 tick;
   logic                 load;

   assign tick    = baud_i & ~baud_q_reg;
   assign ready_o = ~hold_full_reg;
   assign tx_o    = tx_reg;
   assign busy_o  = (state_reg != IDLE) | hold_full_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         baud_q_reg    <= 1'b1;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
         shift_reg     <= '0;
         par_reg       <= 1'b0;
         cnt_reg       <= '0;
         tx_reg        <= 1'b1;
      end else begin
         state_reg     <= state_next;
         baud_q_reg    <= baud_i;
         hold_reg      <= hold_next;
         hold_full_reg <= hold_full_next;
         shift_reg     <= shift_next;
         par_reg       <= par_next;
         cnt_reg       <= cnt_next;
         tx_reg        <= tx_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      hold_next      = hold_reg;
      hold_full_next = hold_full_reg;
      shift_next     = shift_reg;
      par_next       = par_reg;
      cnt_next       = cnt_reg;
      tx_next        = tx_reg;
      load           = 1'b0;

      // Accept only into an empty hold; a full hold is only drained on a tick,
      // so the two never happen in the same cycle.
      if (valid_i && !hold_full_reg) begin
         hold_next      = data_i;
         hold_full_next = 1'b1;
      end

      if (tick) begin
         case (state_reg)
            IDLE: begin
               load = hold_full_reg;
            end
            START: begin
               tx_next    = shift_reg[0];
               shift_next = shift_reg >> 1;
               cnt_next   = '0;
               state_next = DATA;
            end
            DATA: begin
               if (cnt_reg == LAST_DATA) begin
                  if (PARITY != 0) begin
                     tx_next    = par_reg;
                     state_next = PAR;
                  end else begin
                     tx_next    = 1'b1;
                     cnt_next   = '0;
                     state_next = STOP;
                  end
               end else begin
                  tx_next    = shift_reg[0];
                  shift_next = shift_reg >> 1;
                  cnt_next   = cnt_reg + CW'(1);
               end
            end
            PAR: begin
               tx_next    = 1'b1;
               cnt_next   = '0;
               state_next = STOP;
            end
            STOP: begin
               if (cnt_reg == LAST_STOP) begin
                  if (hold_full_reg) begin
                     load = 1'b1;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
            default: begin
               tx_next    = 1'b1;
               state_next = IDLE;
            end
         endcase
      end

      // Parity is taken from the byte being framed, captured as it leaves hold.
      if (load) begin
         shift_next     = hold_reg;
         par_next       = (PARITY == 2) ? ^hold_reg : ~^hold_reg;
         hold_full_next = 1'b0;
         tx_next        = 1'b0;
         state_next     = START;
      end
   end

endmodule
